qvalue_scan: RTL

//  Initiator on the 16-bit-word node memory port (byte address, 2 bytes/word, combinational read,

---
 rtl/qvalue_scan_pkg.sv | 26 ++
 rtl/qvalue_scan_if.sv | 30 +++
 rtl/qvalue_scan.sv | 137 +++++++++++++
 3 files changed

// File: rtl/qvalue_scan_pkg.sv
// Shared memory-map constants and scan FSM state type for the Q-value scanner.
// State set widens when QSCAN_WRITEBACK_EN is defined.
package qvalue_scan_pkg;

    localparam int unsigned MEM_WIDTH  = 8;
    localparam int unsigned WORD_WIDTH = 16;

    localparam logic [10:0] NEIGHBOR_ID_BASE     = 11'h048;
    localparam logic [10:0] QVALUE_BASE          = 11'h1C8;
    localparam logic [10:0] BETTERNBR_BASE       = 11'h668;
    localparam logic [10:0] NBR_COUNT_ADDR       = 11'h68A;
    localparam logic [10:0] BETTERNBR_COUNT_ADDR = 11'h68C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_CNT,
        ST_RD_Q,
        ST_RD_ID,
        ST_DONE
`ifdef QSCAN_WRITEBACK_EN
        , ST_WB_ID
        , ST_WB_CNT
`endif
    } state_t;

endpackage

// File: rtl/qvalue_scan_if.sv
// Request/result handshake plus node-memory port of the Q-value scanner.
// master = scanner side, slave = requester/memory side.
interface qvalue_scan_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned WORD_W = 16
);
    logic              start;
    logic              busy;
    logic              done;
    logic              best_valid;
    logic [WORD_W-1:0] best_id;
    logic [WORD_W-1:0] best_q;
    logic [5:0]        best_idx;
    logic [ADDR_W-1:0] address;
    logic              wr_en;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;

    modport master (
        input  start, data_out,
        output busy, done, best_valid, best_id, best_q, best_idx,
        output address, wr_en, data_in
    );

    modport slave (
        output start, data_out,
        input  busy, done, best_valid, best_id, best_q, best_idx,
        input  address, wr_en, data_in
    );
endinterface

// File: rtl/qvalue_scan.sv
// Scans the neighbor table for the highest unsigned Q-value and reports the winner.
// Define QSCAN_WRITEBACK_EN to write the winner into betterneighbors[0]/betterneighborCount.
module qvalue_scan
    import qvalue_scan_pkg::*;
#(
    parameter int unsigned MAX_NBR = 64,
    parameter int unsigned ADDR_W  = 11,
    parameter int unsigned WORD_W  = 16
) (
    input  logic            clock,
    input  logic            nrst,
    qvalue_scan_if.master   bus
);

    localparam int unsigned CNT_W = $clog2(MAX_NBR + 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  nbr_cnt;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt_clamped;
    logic [WORD_W-1:0] q_cand;
    logic              take;
    logic              last;

    always_comb begin
        if (bus.data_out > WORD_W'(MAX_NBR))
            cnt_clamped = CNT_W'(MAX_NBR);
        else
            cnt_clamped = bus.data_out[CNT_W-1:0];
    end

    // Index 0 always seeds the result; afterwards only a strictly larger Q wins.
    assign take = (idx == '0) || (q_cand > bus.best_q);
    assign last = ((idx + CNT_W'(1)) == nbr_cnt);

    always_comb begin
        state_next  = state;
        bus.address = '0;
        bus.wr_en   = 1'b0;
        bus.data_in = '0;
        bus.busy    = 1'b1;
        bus.done    = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start)
                    state_next = ST_RD_CNT;
            end
            ST_RD_CNT: begin
                bus.address = ADDR_W'(NBR_COUNT_ADDR);
                if (cnt_clamped == '0) begin
`ifdef QSCAN_WRITEBACK_EN
                    state_next = ST_WB_CNT;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    state_next = ST_RD_Q;
                end
            end
            ST_RD_Q: begin
                bus.address = ADDR_W'(QVALUE_BASE) + ADDR_W'({idx, 1'b0});
                state_next  = ST_RD_ID;
            end
            ST_RD_ID: begin
                bus.address = ADDR_W'(NEIGHBOR_ID_BASE) + ADDR_W'({idx, 1'b0});
                if (last) begin
`ifdef QSCAN_WRITEBACK_EN
                    state_next = ST_WB_ID;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    state_next = ST_RD_Q;
                end
            end
`ifdef QSCAN_WRITEBACK_EN
            ST_WB_ID: begin
                bus.address = ADDR_W'(BETTERNBR_BASE);
                bus.wr_en   = 1'b1;
                bus.data_in = bus.best_id;
                state_next  = ST_WB_CNT;
            end
            ST_WB_CNT: begin
                bus.address = ADDR_W'(BETTERNBR_COUNT_ADDR);
                bus.wr_en   = 1'b1;
                bus.data_in = bus.best_valid ? WORD_W'(1) : '0;
                state_next  = ST_DONE;
            end
`endif
            ST_DONE: begin
                bus.done   = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nrst) begin
        if (!nrst) begin
            state          <= ST_IDLE;
            nbr_cnt        <= '0;
            idx            <= '0;
            q_cand         <= '0;
            bus.best_valid <= 1'b0;
            bus.best_id    <= '0;
            bus.best_q     <= '0;
            bus.best_idx   <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        idx            <= '0;
                        bus.best_valid <= 1'b0;
                        bus.best_id    <= '0;
                        bus.best_q     <= '0;
                        bus.best_idx   <= '0;
                    end
                end
                ST_RD_CNT: nbr_cnt <= cnt_clamped;
                ST_RD_Q:   q_cand  <= bus.data_out;
                ST_RD_ID: begin
                    if (take) begin
                        bus.best_q     <= q_cand;
                        bus.best_id    <= bus.data_out;
                        bus.best_idx   <= 6'(idx);
                        bus.best_valid <= 1'b1;
                    end
                    idx <= idx + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
